// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU/register-file command sequencer.
package alu_seq_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      RD1,
      RD2,
      EXEC,
      WB
   } state_t;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_NAND = 2'b10;
   localparam logic [1:0] OP_NOR  = 2'b11;

   localparam logic KIND_ALU  = 1'b0;
   localparam logic KIND_LOAD = 1'b1;

endpackage

// File: rtl/alu_reg_sequencer.sv
// Sequences ALU and LOAD commands over an external register file + ALU datapath:
// read two operands, present them to the ALU, then write the result back.
module alu_reg_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_kind,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [7:0]        cmd_count,
   output logic [DATA_W-1:0] dp_A,
   output logic [DATA_W-1:0] dp_B,
   output logic [1:0]        dp_opcode,
   output logic [ADDR_W-1:0] dp_read_addr,
   output logic [ADDR_W-1:0] dp_write_addr,
   output logic              dp_write_enable,
   input  logic [DATA_W-1:0] dp_read_data,
   input  logic [DATA_W-1:0] dp_alu_result
);

   state_t              state;
   logic [DATA_W-1:0]   opa;
   logic [DATA_W-1:0]   opb;
   logic [1:0]          op_reg;
   logic [ADDR_W-1:0]   src2_reg;
   logic [ADDR_W-1:0]   dst_reg;

   assign cmd_ready = (state == IDLE);

   // Outputs are registered on entry to the state that uses them, so they are
   // already valid for the whole of that state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         opa             <= '0;
         opb             <= '0;
         op_reg          <= OP_AND;
         src2_reg        <= '0;
         dst_reg         <= '0;
         done            <= 1'b0;
         result          <= '0;
         cmd_count       <= '0;
         dp_A            <= '0;
         dp_B            <= '0;
         dp_opcode       <= OP_AND;
         dp_read_addr    <= '0;
         dp_write_addr   <= '0;
         dp_write_enable <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  src2_reg <= cmd_src2;
                  dst_reg  <= cmd_dst;
                  if (cmd_kind == KIND_LOAD) begin
                     // imm | imm == imm, so LOAD reuses the ALU write path
                     opa       <= cmd_imm;
                     opb       <= cmd_imm;
                     op_reg    <= OP_OR;
                     dp_A      <= cmd_imm;
                     dp_B      <= cmd_imm;
                     dp_opcode <= OP_OR;
                     state     <= EXEC;
                  end else begin
                     op_reg       <= cmd_op;
                     dp_read_addr <= cmd_src1;
                     state        <= RD1;
                  end
               end
            end
            RD1: begin
               opa          <= dp_read_data;
               dp_read_addr <= src2_reg;
               state        <= RD2;
            end
            RD2: begin
               opb          <= dp_read_data;
               dp_read_addr <= '0;
               dp_A         <= opa;
               dp_B         <= dp_read_data;
               dp_opcode    <= op_reg;
               state        <= EXEC;
            end
            EXEC: begin
               result          <= dp_alu_result;
               dp_write_addr   <= dst_reg;
               dp_write_enable <= 1'b1;
               done            <= 1'b1;
               state           <= WB;
            end
            WB: begin
               dp_write_enable <= 1'b0;
               done            <= 1'b0;
               cmd_count       <= cmd_count + 8'd1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with a behavioural register file + ALU.
module tb_alu_reg_sequencer;

   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_kind = 1'b0;
   logic [1:0]    cmd_op = 2'b00;
   logic [AW-1:0] cmd_src1 = '0;
   logic [AW-1:0] cmd_src2 = '0;
   logic [AW-1:0] cmd_dst = '0;
   logic [DW-1:0] cmd_imm = '0;
   logic          done;
   logic [DW-1:0] result;
   logic [7:0]    cmd_count;
   logic [DW-1:0] dp_A, dp_B;
   logic [1:0]    dp_opcode;
   logic [AW-1:0] dp_read_addr, dp_write_addr;
   logic          dp_write_enable;
   logic [DW-1:0] dp_read_data, dp_alu_result;

   logic [DW-1:0] rf [8] = '{default: 8'h00};
   int            done_pulses = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   assign dp_read_data = rf[dp_read_addr];

   always_comb begin
      case (dp_opcode)
         2'b00:   dp_alu_result = dp_A & dp_B;
         2'b01:   dp_alu_result = dp_A | dp_B;
         2'b10:   dp_alu_result = ~(dp_A & dp_B);
         default: dp_alu_result = ~(dp_A | dp_B);
      endcase
   end

   always @(posedge clk) begin
      if (dp_write_enable) rf[dp_write_addr] <= dp_alu_result;
      if (done) done_pulses <= done_pulses + 1;
   end

   alu_reg_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
      .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
      .done(done), .result(result), .cmd_count(cmd_count),
      .dp_A(dp_A), .dp_B(dp_B), .dp_opcode(dp_opcode),
      .dp_read_addr(dp_read_addr), .dp_write_addr(dp_write_addr),
      .dp_write_enable(dp_write_enable),
      .dp_read_data(dp_read_data), .dp_alu_result(dp_alu_result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_fields(input logic kind, input logic [1:0] op, input logic [AW-1:0] s1,
                             input logic [AW-1:0] s2, input logic [AW-1:0] d, input logic [DW-1:0] imm);
      cmd_kind = kind; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_imm = imm;
   endtask

   // Issue one command; lat is the cycle index (1 = cycle after accept) where done is seen.
   task automatic send_cmd(input logic kind, input logic [1:0] op, input logic [AW-1:0] s1,
                           input logic [AW-1:0] s2, input logic [AW-1:0] d, input logic [DW-1:0] imm,
                           output int lat, output logic [DW-1:0] res, output logic [AW-1:0] wa,
                           output logic we, output logic [AW-1:0] ra);
      int guard;
      @(negedge clk);
      set_fields(kind, op, s1, s2, d, imm);
      cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      res = result; wa = dp_write_addr; we = dp_write_enable; ra = dp_read_addr;
      @(negedge clk);
   endtask

   typedef struct {
      logic          kind;
      logic [1:0]    op;
      logic [AW-1:0] s1, s2, d;
      logic [DW-1:0] imm;
      logic [DW-1:0] exp_res;
      int            exp_lat;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int            lat;
      logic [DW-1:0] res;
      logic [AW-1:0] wa, ra;
      logic          we;
      logic          rdy [1:5];
      logic          dn [1:5];
      logic [DW-1:0] res_a;
      logic          saw;
      int            pulses0;

      tbl[0] = '{1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 8'hAA, 8'hAA, 2};
      tbl[1] = '{1'b1, 2'b00, 3'd0, 3'd0, 3'd1, 8'hCC, 8'hCC, 2};
      tbl[2] = '{1'b0, 2'b00, 3'd0, 3'd1, 3'd2, 8'h00, 8'h88, 4};
      tbl[3] = '{1'b0, 2'b01, 3'd0, 3'd1, 3'd3, 8'h00, 8'hEE, 4};
      tbl[4] = '{1'b0, 2'b10, 3'd0, 3'd1, 3'd4, 8'h00, 8'h77, 4};
      tbl[5] = '{1'b0, 2'b11, 3'd0, 3'd1, 3'd5, 8'h00, 8'h11, 4};
      tbl[6] = '{1'b0, 2'b00, 3'd2, 3'd2, 3'd2, 8'h00, 8'h88, 4};
      tbl[7] = '{1'b0, 2'b10, 3'd2, 3'd2, 3'd2, 8'h00, 8'h77, 4};

      #1;
      check("rst_done", done, 0);
      check("rst_we", dp_write_enable, 0);
      check("rst_count", cmd_count, 0);
      check("rst_result", result, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", cmd_ready, 1);
      check("rst_dp_a", dp_A, 0);
      check("rst_dp_b", dp_B, 0);
      check("rst_raddr", dp_read_addr, 0);

      for (int i = 0; i < 8; i++) begin
         send_cmd(tbl[i].kind, tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].imm, lat, res, wa, we, ra);
         $display("cmd %0d kind=%0d op=%0d r%0d,r%0d->r%0d imm=%02h: result=%02h lat=%0d count=%0d",
                  i, tbl[i].kind, tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].imm, res, lat, cmd_count);
         check("vec_latency", lat, tbl[i].exp_lat);
         check("vec_result", res, tbl[i].exp_res);
         check("vec_wb_we", we, 1);
         check("vec_wb_waddr", wa, tbl[i].d);
         check("vec_wb_raddr", ra, 0);
         check("vec_rf_dst", rf[tbl[i].d], tbl[i].exp_res);
         check("vec_count", cmd_count, i + 1);
      end

      // Two queued commands with cmd_valid held high; fields switch to B while A runs.
      @(negedge clk);
      set_fields(1'b0, 2'b11, 3'd0, 3'd1, 3'd7, 8'h00);
      cmd_valid = 1'b1;
      check("b2b_ready_a", cmd_ready, 1);
      @(posedge clk);
      res_a = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) set_fields(1'b0, 2'b01, 3'd7, 3'd0, 3'd7, 8'h00);
         rdy[c] = cmd_ready;
         dn[c]  = done;
         if (c == 4) res_a = result;
      end
      for (int c = 1; c <= 5; c++) begin
         check("b2b_ready", rdy[c], (c == 5) ? 1 : 0);
         check("b2b_done", dn[c], (c == 4) ? 1 : 0);
      end
      check("b2b_result_a", res_a, 8'h11);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      $display("b2b second cmd: result=%02h lat=%0d", result, lat);
      check("b2b_latency_b", lat, 4);
      check("b2b_result_b", result, 8'hBB);
      @(negedge clk);
      check("b2b_rf7", rf[7], 8'hBB);
      check("b2b_count", cmd_count, 10);

      // Reset asserted during RD2 of OR r0,r1->r6.
      @(negedge clk);
      set_fields(1'b0, 2'b01, 3'd0, 3'd1, 3'd6, 8'h00);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_rd2_raddr", dp_read_addr, 1);
      reset = 1'b0;
      #1;
      check("abort_we", dp_write_enable, 0);
      check("abort_done", done, 0);
      check("abort_count", cmd_count, 0);
      check("abort_result", result, 0);
      check("abort_raddr", dp_read_addr, 0);
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         saw = saw | done | dp_write_enable;
      end
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         saw = saw | done | dp_write_enable;
      end
      $display("abort: done/we seen=%0d r6=%02h count=%0d", saw, rf[6], cmd_count);
      check("abort_no_pulse", saw, 0);
      check("abort_rf6", rf[6], 8'h00);
      check("abort_count_after", cmd_count, 0);
      check("abort_ready", cmd_ready, 1);

      // 256 LOADs wrap the counter back to zero.
      pulses0 = done_pulses;
      for (int i = 0; i < 256; i++) begin
         send_cmd(1'b1, 2'b00, 3'd0, 3'd0, 3'(i % 8), 8'(i), lat, res, wa, we, ra);
         if (i == 254) check("wrap_count_255", cmd_count, 255);
      end
      $display("256 loads: count=%0d done pulses=%0d last result=%02h", cmd_count, done_pulses - pulses0, res);
      check("wrap_count_0", cmd_count, 0);
      check("wrap_pulses", done_pulses - pulses0, 256);
      check("wrap_last_result", res, 8'hFF);
      check("wrap_rf7", rf[7], 8'hFF);
      check("wrap_last_latency", lat, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_reg_sequencer.md
ALU_REG_SEQUENCER -- requirements
Module: alu_reg_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, operand/result width; ADDR_W, 3, register-file address width.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command present; cmd_ready  out  1  sequencer can accept.
REQ-005 cmd_kind  in  1  0=ALU (dst = src1 op src2), 1=LOAD (dst = cmd_imm).
REQ-006 cmd_op  in  2  ALU opcode: 00 AND, 01 OR, 10 NAND, 11 NOR.
REQ-007 cmd_src1, cmd_src2, cmd_dst  in  ADDR_W each  register indices; cmd_imm  in  DATA_W  LOAD value.
REQ-008 done  out  1  one-cycle completion pulse; result  out  DATA_W  value written by last command.
REQ-009 cmd_count  out  8  completed-command counter.
REQ-010 dp_A, dp_B  out  DATA_W; dp_opcode  out  2; dp_read_addr, dp_write_addr  out  ADDR_W; dp_write_enable  out  1: drive the ALU/register-file datapath.
REQ-011 dp_read_data, dp_alu_result  in  DATA_W: combinational read port and ALU output of the datapath; write occurs on clk rise when dp_write_enable=1, storing dp_alu_result.

Function
REQ-012 FSM states SHALL be IDLE, RD1, RD2, EXEC, WB; cmd_ready=1 only in IDLE.
REQ-013 Accept = cmd_valid & cmd_ready at a clk rise; all cmd_* fields latched then, ignored otherwise.
REQ-014 ALU path: IDLE->RD1->RD2->EXEC->WB->IDLE; LOAD path: IDLE->EXEC->WB->IDLE.
REQ-015 RD1: dp_read_addr=src1, opa<=dp_read_data at exit; RD2: dp_read_addr=src2, opb<=dp_read_data at exit.
REQ-016 LOAD: opa and opb SHALL both be set to cmd_imm at accept, opcode forced to 01 (OR), yielding imm.
REQ-017 EXEC and WB: dp_A=opa, dp_B=opb, dp_opcode=latched op held stable; result<=dp_alu_result at EXEC exit.
REQ-018 WB: dp_write_enable=1, dp_write_addr=dst, done=1; dp_write_enable=0 in every other state.
REQ-019 Latency: done high in 4th cycle after accept edge (ALU), 2nd cycle (LOAD); throughput one command per 5 (ALU) / 3 (LOAD) cycles.
REQ-020 cmd_valid during non-IDLE states SHALL be held off (no accept, no loss while held).
REQ-021 Read-after-write: a command reading the previous dst SHALL see the written value (write completes at WB exit, before next RD1).
REQ-022 src1==src2==dst SHALL be legal and produce the correct result.
REQ-023 cmd_count increments at WB exit, wrapping 255->0.
REQ-024 dp_read_addr=0 and dp_A/dp_B/dp_opcode/dp_write_addr hold prior values outside their active states.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, dp_write_enable=0, done=0, result=0, cmd_count=0, opa=opb=0, all dp_* outputs 0, cmd_ready=1 once reset=1.
REQ-026 Reset mid-command SHALL abort it with no register-file write and no done pulse.

Structure
REQ-027 Package alu_seq_pkg SHALL hold the state enum, opcode constants (AND/OR/NAND/NOR), cmd_kind constants, default widths.
REQ-028 No sub-module; the datapath is instantiated beside the sequencer by the parent.

Verification
REQ-029 LOAD 0xAA->r0, LOAD 0xCC->r1 -> done 2 cycles after each accept, result 0xAA then 0xCC, cmd_count=2.
REQ-030 ALU AND r0,r1->r2 -> done exactly 4 cycles after accept, result 0x88; OR->r3 0xEE; NAND->r4 0x77; NOR->r5 0x11.
REQ-031 cmd_valid held high with two queued ALU commands -> cmd_ready low RD1..WB, second accepted in IDLE cycle after WB, no command dropped.
REQ-032 AND r2,r2->r2 immediately after REQ-030 -> result 0x88; NAND r2,r2->r2 next -> 0x77.
REQ-033 reset low during RD2 of an OR->r6 -> dp_write_enable 0 same cycle, no done, r6 unchanged, cmd_count 0.
REQ-034 256 LOAD commands -> cmd_count wraps to 0, done pulses counted = 256.
